grey_code_counter: RTL and testbench

Parameterised n-bit Grey-code sequence source that drives the Grey-to-binary converter stage downstream. Holds a binary count, presents its Grey encoding as a registered word under a valid/ready handshake, and advances by one code per accepted word. Supports up/down direction, synchronous load, continuous or single-pass operation, and a wrap pulse. The downstream converter's output must equal the `bin` port of this block for every accepted word.

---
 rtl/grey_code_counter_pkg.sv | 13 +
 rtl/grey_code_counter_if.sv | 27 ++
 rtl/grey_code_counter_bin_to_grey_conv.sv | 11 +
 rtl/grey_code_counter_chk.sv | 31 +++
 rtl/grey_code_counter.sv | 105 ++++++++++
 tb/tb_grey_code_counter.sv | 198 +++++++++++++++++++
 6 files changed

// File: rtl/grey_code_counter_pkg.sv
// Shared definitions for the Grey-code sequence source: state encoding and
// the binary-to-Grey mapping used by the design checker and the bench.
package grey_code_counter_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Wide enough for any practical count; callers keep the low n bits.
    function automatic logic [31:0] bin2grey(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/grey_code_counter_if.sv
// Control and stream bundle between the Grey-code source (master) and its
// controller/consumer (slave).
interface grey_code_counter_if #(
    parameter int n = 3
);
    logic         start;
    logic         stop;
    logic         single;
    logic         up_dn;
    logic         load;
    logic [n-1:0] load_bin;
    logic         ready;
    logic         valid;
    logic [n-1:0] grey;
    logic [n-1:0] bin;
    logic         wrap;

    modport master (
        input  start, stop, single, up_dn, load, load_bin, ready,
        output valid, grey, bin, wrap
    );

    modport slave (
        output start, stop, single, up_dn, load, load_bin, ready,
        input  valid, grey, bin, wrap
    );
endinterface

// File: rtl/grey_code_counter_bin_to_grey_conv.sv
// Combinational n-bit binary to Grey conversion.
module bin_to_grey_conv #(
    parameter int n = 3
) (
    input  logic [n-1:0] bin,
    output logic [n-1:0] grey
);

    assign grey = bin ^ (bin >> 1);

endmodule

// File: rtl/grey_code_counter_chk.sv
// Property checker for the Grey-code source: encoding consistency, stable
// word under backpressure, and wrap landing on an end of the range.
module grey_code_counter_chk
    import grey_code_counter_pkg::*;
#(
    parameter int n = 3
) (
    input logic         clk,
    input logic         rst,
    input logic         valid,
    input logic         ready,
    input logic         load,
    input logic [n-1:0] bin,
    input logic [n-1:0] grey,
    input logic         wrap
);

    logic [31:0] grey_exp_s;

    assign grey_exp_s = bin2grey(32'(bin));

    grey_matches_bin: assert property (@(posedge clk) disable iff (rst)
        grey == grey_exp_s[n-1:0]);

    hold_under_backpressure: assert property (@(posedge clk) disable iff (rst)
        (valid && !ready && !load) |=> (grey == $past(grey)));

    wrap_at_range_end: assert property (@(posedge clk) disable iff (rst)
        wrap |-> ((bin == {n{1'b0}}) || (bin == {n{1'b1}})));

endmodule

// File: rtl/grey_code_counter.sv
// Grey-code sequence source: binary counter with registered Grey output,
// valid/ready handshake, up/down, load, single-pass mode and wrap pulse.
module grey_code_counter
    import grey_code_counter_pkg::*;
#(
    parameter int n = 3
) (
    input  logic                clk,
    input  logic                rst,
    grey_code_counter_if.master bus
);

    localparam logic [n-1:0] CNT_ZERO = {n{1'b0}};
    localparam logic [n-1:0] CNT_MAX  = {n{1'b1}};
    localparam logic [n-1:0] CNT_ONE  = n'(1'b1);

    logic [0:0]   state_r;
    logic [0:0]   state_nxt_s;
    logic [n-1:0] bin_r;
    logic [n-1:0] bin_nxt_s;
    logic [n-1:0] grey_r;
    logic [n-1:0] grey_nxt_s;
    logic         wrap_r;
    logic         wrap_nxt_s;
    logic         transfer_s;
    logic         advance_s;

    // The offered word is the registered state, so valid is simply RUN.
    assign transfer_s = (state_r == ST_RUN) & bus.ready;
    assign advance_s  = transfer_s & ~bus.load;

    // Next count: load beats advance, and only a counting step can wrap.
    always_comb begin
        bin_nxt_s  = bin_r;
        wrap_nxt_s = 1'b0;
        if (bus.load) begin
            bin_nxt_s = bus.load_bin;
        end else if (advance_s) begin
            if (bus.up_dn) begin
                bin_nxt_s  = bin_r + CNT_ONE;
                wrap_nxt_s = (bin_r == CNT_MAX);
            end else begin
                bin_nxt_s  = bin_r - CNT_ONE;
                wrap_nxt_s = (bin_r == CNT_ZERO);
            end
        end else begin
            bin_nxt_s = bin_r;
        end
    end

    // State: stop wins over everything, then single-pass wrap, then start.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus.single && wrap_nxt_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    bin_to_grey_conv #(
        .n (n)
    ) u_conv (
        .bin  (bin_nxt_s),
        .grey (grey_nxt_s)
    );

    // Output and state registers; grey is encoded from the next count so it
    // always pairs with bin in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            bin_r   <= CNT_ZERO;
            grey_r  <= CNT_ZERO;
            wrap_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            bin_r   <= bin_nxt_s;
            grey_r  <= grey_nxt_s;
            wrap_r  <= wrap_nxt_s;
        end
    end

    assign bus.valid = state_r;
    assign bus.bin   = bin_r;
    assign bus.grey  = grey_r;
    assign bus.wrap  = wrap_r;

endmodule

// File: tb/tb_grey_code_counter.sv
// Directed bench for grey_code_counter (n=3) paired with a downstream
// Grey-to-binary converter model that must reproduce bin on every transfer.
module tb_grey_code_counter;
    import grey_code_counter_pkg::*;

    localparam int N = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;
    int   words;

    grey_code_counter_if #(.n(N)) bus ();

    grey_code_counter #(.n(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    grey_code_counter_chk #(.n(N)) chk (
        .clk   (clk),
        .rst   (rst),
        .valid (bus.valid),
        .ready (bus.ready),
        .load  (bus.load),
        .bin   (bus.bin),
        .grey  (bus.grey),
        .wrap  (bus.wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream converter stage.
    function automatic logic [N-1:0] grey2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; any transfer at this edge is checked through the converter.
    task automatic tick();
        if (bus.valid && bus.ready && !rst) begin
            check_eq("conv_vs_bin", 32'(grey2bin(bus.grey)), 32'(bus.bin));
        end
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] up_grey_tbl [8];
    logic [N-1:0] dn_grey_tbl [7];

    initial begin
        up_grey_tbl = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
        dn_grey_tbl = '{3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000, 3'b100};
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.single = 1'b0; bus.up_dn = 1'b1;
        bus.load = 1'b0;  bus.load_bin = 3'd0; bus.ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_valid", 32'(bus.valid), 32'd0);
        check_eq("rst_bin",   32'(bus.bin),   32'd0);
        check_eq("rst_grey",  32'(bus.grey),  32'd0);
        check_eq("rst_wrap",  32'(bus.wrap),  32'd0);

        // Up count, full cycle with wrap.
        bus.ready = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_eq("up_valid", 32'(bus.valid), 32'd1);
            check_eq("up_grey",  32'(bus.grey),  32'(up_grey_tbl[k]));
            check_eq("up_bin",   32'(bus.bin),   32'(k));
            check_eq("up_wrap",  32'(bus.wrap),  32'd0);
            tick();
        end
        check_eq("wrap_grey", 32'(bus.grey), 32'd0);
        check_eq("wrap_set",  32'(bus.wrap), 32'd1);
        tick();
        check_eq("wrap_clr",  32'(bus.wrap), 32'd0);
        tick(); tick();

        // Backpressure at count 3.
        check_eq("bp_pre_grey", 32'(bus.grey), 32'b010);
        bus.ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("bp_valid", 32'(bus.valid), 32'd1);
            check_eq("bp_grey",  32'(bus.grey),  32'b010);
        end
        bus.ready = 1'b1;
        tick();
        check_eq("bp_resume", 32'(bus.grey), 32'b110);

        // Stop with a transfer: word consumed, count advances, valid drops.
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_eq("stop_valid", 32'(bus.valid), 32'd0);
        check_eq("stop_bin",   32'(bus.bin),   32'd5);

        // Load 5 in IDLE, then count down through the 0->7 wrap.
        bus.load = 1'b1; bus.load_bin = 3'd5;
        tick();
        bus.load = 1'b0;
        check_eq("ld_grey",  32'(bus.grey),  32'b111);
        check_eq("ld_valid", 32'(bus.valid), 32'd0);
        bus.up_dn = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check_eq("dn_grey", 32'(bus.grey), 32'(dn_grey_tbl[k]));
            check_eq("dn_wrap", 32'(bus.wrap), (k == 6) ? 32'd1 : 32'd0);
            tick();
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_eq("dn_stop_valid", 32'(bus.valid), 32'd0);

        // Single pass from 0.
        bus.load = 1'b1; bus.load_bin = 3'd0;
        tick();
        bus.load = 1'b0;
        bus.single = 1'b1; bus.up_dn = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        words = 0;
        for (int c = 0; c < 20 && bus.valid; c++) begin
            check_eq("sp_bin",  32'(bus.bin),  32'(words));
            check_eq("sp_grey", 32'(bus.grey), bin2grey(32'(words)));
            words++;
            tick();
        end
        check_eq("sp_words", 32'(words),     32'd8);
        check_eq("sp_valid", 32'(bus.valid), 32'd0);
        check_eq("sp_bin_end", 32'(bus.bin), 32'd0);
        check_eq("sp_wrap",  32'(bus.wrap),  32'd1);
        bus.single = 1'b0;

        // Load during a transfer at count 2.
        bus.load = 1'b1; bus.load_bin = 3'd2;
        tick();
        bus.load = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq("lt_pre_grey", 32'(bus.grey), 32'b011);
        bus.load = 1'b1; bus.load_bin = 3'd6;
        tick();
        bus.load = 1'b0;
        check_eq("lt_grey",  32'(bus.grey),  32'b101);
        check_eq("lt_wrap",  32'(bus.wrap),  32'd0);
        check_eq("lt_valid", 32'(bus.valid), 32'd1);

        // Reset mid-run at count 4.
        bus.ready = 1'b0; bus.load = 1'b1; bus.load_bin = 3'd4;
        tick();
        bus.load = 1'b0;
        check_eq("mr_bin", 32'(bus.bin), 32'd4);
        bus.ready = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mr_valid", 32'(bus.valid), 32'd0);
        check_eq("mr_bin0",  32'(bus.bin),   32'd0);
        check_eq("mr_grey",  32'(bus.grey),  32'd0);
        check_eq("mr_wrap",  32'(bus.wrap),  32'd0);

        // Start and stop together, from IDLE and from RUN.
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        check_eq("ss_idle_valid", 32'(bus.valid), 32'd0);
        bus.stop = 1'b0;
        tick();
        check_eq("ss_run_valid", 32'(bus.valid), 32'd1);
        bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        check_eq("ss_back_idle", 32'(bus.valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
